usb_jtag_fifo_bridge: RTL and testbench
=======================================

# usb_jtag_fifo_bridge

Parametrised host-side bridge between the USB-Blaster JTAG serial pins (TCK/TCS/TDI/TDO) and a word-wide host interface. Unlike the previous byte bridge, all JTAG pins are oversampled in the iCLK domain, so there is no TCK-clocked logic. Word width is configurable, both directions are buffered in FIFOs, and overflow and abort conditions are reported. It sits between the board JTAG pins and the host-side UART/command logic.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per serial word; must be ≥2.
- RX_DEPTH, 16: RX FIFO entries; power of two, ≥2.
- TX_DEPTH, 16: TX FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on TCK, TCS and TDI; ≥2.

Ports:
- iCLK  in  1  system clock; the only clock.
- iRST_n  in  1  asynchronous, active-low reset.
- TCK  in  1  JTAG clock, asynchronous to iCLK.
- TCS  in  1  JTAG select; active high = idle/abort.
- TDI  in  1  serial data from host.
- TDO  out  1  serial data to host.
- iTxD_DATA  in  DATA_WIDTH  word to transmit.
- iTxD_Start  in  1  push strobe; writes iTxD_DATA into the TX FIFO.
- oTxD_Full  out  1  TX FIFO full.
- oTxD_Done  out  1  one-cycle pulse per word fully shifted out.
- oRxD_DATA  out  DATA_WIDTH  RX FIFO head (first-word fall-through).
- oRxD_Ready  out  1  RX FIFO non-empty.
- iRxD_Ack  in  1  pops the RX head; ignored when empty.
- oRxD_Level  out  $clog2(RX_DEPTH+1)  RX occupancy.
- oRx_Overflow  out  1  sticky: a received word was dropped.
- oTx_Abort  out  1  sticky: TCS rose during a TX word.
- iClr_Status  in  1  clears both sticky flags.

## Operation
- TCK, TCS and TDI each pass through SYNC_STAGES flops. tck_rise = synced TCK is 1 and its previous value was 0. TDI is sampled from the same sync stage as TCK.
- Active edge: tck_rise while synced TCS is low.
- Synced TCS high:
  - rx_cnt and tx_cnt are held at 0, the partial RX shift register is discarded, and TDO is 0.
  - If tx_cnt≠0 when TCS rises, the popped word is lost, oTx_Abort is set, and there is no oTxD_Done pulse.
- RX path:
  - Each active edge shifts TDI in LSB-first: rx_sr ← {TDI, rx_sr[DATA_WIDTH-1:1]}, and rx_cnt increments.
  - When rx_cnt reaches DATA_WIDTH-1, the assembled word is pushed into the RX FIFO on the next cycle and rx_cnt wraps to 0.
  - Push while full and iRxD_Ack low: the word is dropped and oRx_Overflow is set.
  - Push while full with iRxD_Ack high in the same cycle: both happen and the level is unchanged.
- TX path:
  - At an active edge with tx_cnt=0:
    - FIFO non-empty: pop the head, TDO ← word[0], tx_sr ← word, tx_cnt ← 1.
    - FIFO empty: TDO ← 0 and tx_cnt stays 0 (idle zeros).
  - At an active edge with tx_cnt=k≠0: TDO ← tx_sr[k] and tx_cnt increments.
  - After bit DATA_WIDTH-1 is driven, tx_cnt wraps to 0 and oTxD_Done pulses for one cycle.
- TX write: iTxD_Start while oTxD_Full is set is ignored. A pop and a push in the same cycle on a full FIFO are both accepted.
- iClr_Status clears the sticky flags. If a new overflow or abort occurs in the same cycle, set wins.
- FIFO pointers carry an extra wrap bit. Full/empty are derived from the pointers; level = wr − rd (modulo).

## Timing
- Reset values:
  - TDO=0, oTxD_Done=0, oTxD_Full=0, oRxD_Ready=0, oRxD_Level=0, oRx_Overflow=0, oTx_Abort=0.
  - oRxD_DATA is undefined while empty.
  - All counters and pointers are 0.
  - Reset mid-word discards everything in flight.
- TCK pin edge to internal tck_rise: SYNC_STAGES+1 iCLK cycles.
- TDO changes 1 cycle after tck_rise. TCK high and low phases must each last ≥ SYNC_STAGES+2 iCLK cycles.
- RX, final active edge → oRxD_Ready: push at +1, flag at +2 cycles.
- iRxD_Ack at cycle n: the next head is valid on oRxD_DATA at n+1.
- iTxD_Start at cycle n: oTxD_Full and the FIFO contents update at n+1. The word is eligible for the next tx_cnt=0 active edge after n+1.
- oTxD_Done: one cycle, 1 cycle after the edge that drives the last bit.
- RX and TX are independent and run simultaneously on the same TCK edges.

## Test plan
- RX byte, default parameters: shift TDI LSB-first 0xA5 with TCS low → oRxD_Ready rises, oRxD_DATA=0xA5, oRxD_Level=1; iRxD_Ack → Ready=0, Level=0.
- TX pair: push 0x3C and 0x81, then clock 16 TCK → TDO sequence 0,0,1,1,1,1,0,0 then 1,0,0,0,0,0,0,1; oTxD_Done pulses twice; a further 8 TCK give TDO=0.
- RX overflow, RX_DEPTH=4: send 5 words with no ack → Level=4, oRx_Overflow=1, and the FIFO holds words 1–4. Then iClr_Status → 0.
- Abort: TCS high after 3 bits of RX and TX words → no push, no Done, oTx_Abort=1. The next word after TCS low is received and sent intact.
- Parametrisation: DATA_WIDTH=12, send 0xABC → oRxD_DATA=0xABC after 12 edges. Loop TDO→TDI under random TCK phase lengths ≥4 cycles → data matches.
- Reset mid-transfer: assert iRST_n low after 5 bits with both FIFOs partly full → all outputs at reset values and FIFOs empty.

Source files
------------

// File: rtl/usb_jtag_fifo_bridge_if.sv
// Host-side word interface of the USB-Blaster JTAG FIFO bridge.
// master = host logic, slave = bridge.
interface usb_jtag_fifo_bridge_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RX_DEPTH   = 16
);
  localparam int unsigned LVL_W = $clog2(RX_DEPTH + 1);

  logic [DATA_WIDTH-1:0] iTxD_DATA;
  logic                  iTxD_Start;
  logic                  oTxD_Full;
  logic                  oTxD_Done;
  logic [DATA_WIDTH-1:0] oRxD_DATA;
  logic                  oRxD_Ready;
  logic                  iRxD_Ack;
  logic [LVL_W-1:0]      oRxD_Level;
  logic                  oRx_Overflow;
  logic                  oTx_Abort;
  logic                  iClr_Status;

  modport master (
    output iTxD_DATA, iTxD_Start, iRxD_Ack, iClr_Status,
    input  oTxD_Full, oTxD_Done, oRxD_DATA, oRxD_Ready, oRxD_Level,
           oRx_Overflow, oTx_Abort
  );

  modport slave (
    input  iTxD_DATA, iTxD_Start, iRxD_Ack, iClr_Status,
    output oTxD_Full, oTxD_Done, oRxD_DATA, oRxD_Ready, oRxD_Level,
           oRx_Overflow, oTx_Abort
  );
endinterface

// File: rtl/usb_jtag_fifo_bridge.sv
// USB-Blaster JTAG pin bridge: TCK/TCS/TDI oversampled in iCLK, words buffered
// in RX/TX FIFOs with sticky overflow/abort status.
module usb_jtag_fifo_bridge #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     TCK,
  input  logic                     TCS,
  input  logic                     TDI,
  output logic                     TDO,
  usb_jtag_fifo_bridge_if.slave    host
);
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned LVL_W = $clog2(RX_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] tck_sync_q, tcs_sync_q, tdi_sync_q;
  logic                   tck_prev_q;
  logic                   tck_s, tcs_s, tdi_s, active;

  // TCS resets high so the link starts idle until the host selects it.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tck_sync_q <= '0;
      tcs_sync_q <= '1;
      tdi_sync_q <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], TCK};
      tcs_sync_q <= {tcs_sync_q[SYNC_STAGES-2:0], TCS};
      tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], TDI};
      tck_prev_q <= tck_s;
    end
  end

  assign tck_s  = tck_sync_q[SYNC_STAGES-1];
  assign tcs_s  = tcs_sync_q[SYNC_STAGES-1];
  assign tdi_s  = tdi_sync_q[SYNC_STAGES-1];
  assign active = tck_s & ~tck_prev_q & ~tcs_s;

  // ---------------- RX shifter and FIFO ----------------
  logic [DATA_WIDTH-1:0] rx_sr_q;
  logic [CNT_W-1:0]      rx_cnt_q;
  logic                  rx_push_q;
  logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];
  logic [RX_AW:0]        rx_wr_q, rx_rd_q;
  logic                  rx_empty, rx_full, rx_pop, rx_wr_en, rx_ovf_set;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rx_sr_q   <= '0;
      rx_cnt_q  <= '0;
      rx_push_q <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      if (tcs_s) begin
        rx_sr_q  <= '0;
        rx_cnt_q <= '0;
      end else if (active) begin
        rx_sr_q <= {tdi_s, rx_sr_q[DATA_WIDTH-1:1]};
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_q  <= '0;
          rx_push_q <= 1'b1;
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
      end
    end
  end

  assign rx_empty   = (rx_wr_q == rx_rd_q);
  assign rx_full    = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign rx_pop     = host.iRxD_Ack & ~rx_empty;
  assign rx_wr_en   = rx_push_q & (~rx_full | rx_pop);
  assign rx_ovf_set = rx_push_q & rx_full & ~rx_pop;

  always_ff @(posedge iCLK) begin
    if (rx_wr_en) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= rx_sr_q;
  end

  // ---------------- TX FIFO and shifter ----------------
  logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
  logic [TX_AW:0]        tx_wr_q, tx_rd_q;
  logic                  tx_empty, tx_full, tx_pop, tx_push, tx_abort_set;
  logic [DATA_WIDTH-1:0] tx_head, tx_sr_q;
  logic [CNT_W-1:0]      tx_cnt_q;
  logic                  tdo_q, done_q, ovf_q, abort_q;

  assign tx_empty     = (tx_wr_q == tx_rd_q);
  assign tx_full      = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                        (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  assign tx_head      = tx_mem_q[tx_rd_q[TX_AW-1:0]];
  assign tx_pop       = active & (tx_cnt_q == '0) & ~tx_empty;
  assign tx_push      = host.iTxD_Start & (~tx_full | tx_pop);
  assign tx_abort_set = tcs_s & (tx_cnt_q != '0);

  always_ff @(posedge iCLK) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= host.iTxD_DATA;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (rx_wr_en) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)   rx_rd_q <= rx_rd_q + 1'b1;
      if (tx_push)  tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)   tx_rd_q <= tx_rd_q + 1'b1;
      // A new event in the same cycle as a clear keeps the flag set.
      ovf_q   <= (ovf_q   & ~host.iClr_Status) | rx_ovf_set;
      abort_q <= (abort_q & ~host.iClr_Status) | tx_abort_set;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tx_sr_q  <= '0;
      tx_cnt_q <= '0;
      tdo_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tcs_s) begin
        tx_cnt_q <= '0;
        tdo_q    <= 1'b0;
      end else if (active) begin
        if (tx_cnt_q == '0) begin
          if (!tx_empty) begin
            tdo_q    <= tx_head[0];
            tx_sr_q  <= tx_head;
            tx_cnt_q <= CNT_W'(1);
          end else begin
            tdo_q <= 1'b0;
          end
        end else begin
          tdo_q <= tx_sr_q[tx_cnt_q];
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            done_q   <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign TDO               = tdo_q;
  assign host.oTxD_Full    = tx_full;
  assign host.oTxD_Done    = done_q;
  assign host.oRxD_DATA    = rx_mem_q[rx_rd_q[RX_AW-1:0]];
  assign host.oRxD_Ready   = ~rx_empty;
  assign host.oRxD_Level   = LVL_W'(rx_wr_q - rx_rd_q);
  assign host.oRx_Overflow = ovf_q;
  assign host.oTx_Abort    = abort_q;
endmodule

// File: tb/tb_usb_jtag_fifo_bridge.sv
// Randomised bench for usb_jtag_fifo_bridge: two instances (8-bit/4-deep and
// 12-bit/16-deep with TDO->TDI loopback) against a queue-based serial model.
module tb_usb_jtag_fifo_bridge;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck = 1'b0, tcs = 1'b1, tdi = 1'b0, loop_en = 1'b0;
  int unsigned sel = 0;
  logic tck_a, tcs_a, tdo_a, tck_b, tcs_b, tdi_b, tdo_b;

  always #5 clk = ~clk;

  // The deselected instance sees TCS high so it stays idle.
  assign tck_a = (sel == 0) ? tck : 1'b0;
  assign tcs_a = (sel == 0) ? tcs : 1'b1;
  assign tck_b = (sel == 1) ? tck : 1'b0;
  assign tcs_b = (sel == 1) ? tcs : 1'b1;
  assign tdi_b = loop_en ? tdo_b : tdi;

  usb_jtag_fifo_bridge_if #(.DATA_WIDTH(8),  .RX_DEPTH(4))  ifa ();
  usb_jtag_fifo_bridge_if #(.DATA_WIDTH(12), .RX_DEPTH(16)) ifb ();

  usb_jtag_fifo_bridge #(.DATA_WIDTH(8), .RX_DEPTH(4), .TX_DEPTH(4), .SYNC_STAGES(SYNC)) dut_a (
    .iCLK(clk), .iRST_n(rst_n), .TCK(tck_a), .TCS(tcs_a), .TDI(tdi), .TDO(tdo_a), .host(ifa)
  );
  usb_jtag_fifo_bridge #(.DATA_WIDTH(12), .RX_DEPTH(16), .TX_DEPTH(16), .SYNC_STAGES(SYNC)) dut_b (
    .iCLK(clk), .iRST_n(rst_n), .TCK(tck_b), .TCS(tcs_b), .TDI(tdi_b), .TDO(tdo_b), .host(ifb)
  );

  logic [11:0] o_data;
  logic [4:0]  o_level;
  logic        o_ready, o_full, o_done, o_ovf, o_abort, o_tdo;

  always_comb begin
    if (sel == 0) begin
      o_data  = 12'(ifa.oRxD_DATA);
      o_level = 5'(ifa.oRxD_Level);
      o_ready = ifa.oRxD_Ready;
      o_full  = ifa.oTxD_Full;
      o_done  = ifa.oTxD_Done;
      o_ovf   = ifa.oRx_Overflow;
      o_abort = ifa.oTx_Abort;
      o_tdo   = tdo_a;
    end else begin
      o_data  = ifb.oRxD_DATA;
      o_level = ifb.oRxD_Level;
      o_ready = ifb.oRxD_Ready;
      o_full  = ifb.oTxD_Full;
      o_done  = ifb.oTxD_Done;
      o_ovf   = ifb.oRx_Overflow;
      o_abort = ifb.oTx_Abort;
      o_tdo   = tdo_b;
    end
  end

  // Counts cycles with Done high, so a stretched pulse also shows up.
  int unsigned done_seen = 0;
  always @(negedge clk) if (o_done === 1'b1) done_seen++;

  int unsigned n_checks = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned dw, rx_depth, tx_depth;
  int unsigned m_rxq[$], m_txq[$];
  bit          m_bits[$];
  int unsigned m_acc, m_n, m_done = 0;
  bit          m_tdo, m_ovf, m_abort;

  task automatic model_reset();
    m_rxq.delete(); m_txq.delete(); m_bits.delete();
    m_acc = 0; m_n = 0; m_tdo = 0; m_ovf = 0; m_abort = 0;
  endtask

  task automatic model_edge(input bit b);
    bit rb;
    int unsigned w;
    rb = loop_en ? m_tdo : b;
    m_acc |= int'(rb) << m_n;
    m_n++;
    if (m_n == dw) begin
      if (m_rxq.size() < rx_depth) m_rxq.push_back(m_acc);
      else m_ovf = 1;
      m_acc = 0; m_n = 0;
    end
    if (m_bits.size() == 0 && m_txq.size() != 0) begin
      w = m_txq.pop_front();
      for (int i = 0; i < int'(dw); i++) m_bits.push_back(((w >> i) & 1) != 0);
    end
    if (m_bits.size() != 0) begin
      m_tdo = m_bits.pop_front();
      if (m_bits.size() == 0) m_done++;
    end else begin
      m_tdo = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".tdo"},   32'(o_tdo),   32'(m_tdo));
    check_eq({tag, ".ready"}, 32'(o_ready), (m_rxq.size() != 0) ? 1 : 0);
    check_eq({tag, ".level"}, 32'(o_level), m_rxq.size());
    if (m_rxq.size() != 0) check_eq({tag, ".data"}, 32'(o_data), m_rxq[0]);
    check_eq({tag, ".full"},  32'(o_full),  (m_txq.size() == tx_depth) ? 1 : 0);
    check_eq({tag, ".ovf"},   32'(o_ovf),   32'(m_ovf));
    check_eq({tag, ".abort"}, 32'(o_abort), 32'(m_abort));
    check_eq({tag, ".done"},  done_seen,    m_done);
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic tck_pulse(input bit b, input int unsigned hi, input int unsigned lo);
    @(negedge clk);
    tdi = b;
    tck = 1'b1;
    repeat (hi) @(negedge clk);
    tck = 1'b0;
    if (!tcs) model_edge(b);
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_word(input int unsigned w);
    for (int i = 0; i < int'(dw); i++) tck_pulse(((w >> i) & 1) != 0, 4, 4);
  endtask

  task automatic set_tcs(input bit v);
    @(negedge clk);
    tcs = v;
    repeat (SYNC + 3) @(negedge clk);
    if (v) begin
      if (m_bits.size() != 0) m_abort = 1;
      m_bits.delete();
      m_acc = 0; m_n = 0; m_tdo = 0;
    end
  endtask

  task automatic host_push(input int unsigned w);
    int unsigned v;
    v = w & ((1 << dw) - 1);
    @(negedge clk);
    if (sel == 0) begin ifa.iTxD_Start = 1'b1; ifa.iTxD_DATA = 8'(v); end
    else          begin ifb.iTxD_Start = 1'b1; ifb.iTxD_DATA = 12'(v); end
    @(negedge clk);
    ifa.iTxD_Start = 1'b0;
    ifb.iTxD_Start = 1'b0;
    if (m_txq.size() < tx_depth) m_txq.push_back(v);
  endtask

  task automatic host_ack();
    @(negedge clk);
    if (sel == 0) ifa.iRxD_Ack = 1'b1; else ifb.iRxD_Ack = 1'b1;
    @(negedge clk);
    ifa.iRxD_Ack = 1'b0;
    ifb.iRxD_Ack = 1'b0;
    if (m_rxq.size() != 0) void'(m_rxq.pop_front());
  endtask

  task automatic host_clr();
    @(negedge clk);
    if (sel == 0) ifa.iClr_Status = 1'b1; else ifb.iClr_Status = 1'b1;
    @(negedge clk);
    ifa.iClr_Status = 1'b0;
    ifb.iClr_Status = 1'b0;
    m_ovf = 0; m_abort = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    tck = 1'b0;
    tcs = 1'b1;
    model_reset();
    #1;
    check_all("in_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  task automatic use_dut(input int unsigned s);
    sel = s;
    loop_en = 1'b0;
    dw       = (s == 0) ? 8 : 12;
    rx_depth = (s == 0) ? 4 : 16;
    tx_depth = (s == 0) ? 4 : 16;
    do_reset();
  endtask

  task automatic drain_rx();
    for (int i = 0; i < 20 && m_rxq.size() != 0; i++) host_ack();
  endtask

  task automatic random_ops(input int unsigned n, input string tag);
    int unsigned r;
    for (int i = 0; i < int'(n); i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       tck_pulse($urandom_range(0, 1) != 0, $urandom_range(4, 7), $urandom_range(4, 7));
      else if (r < 7)  host_push($urandom);
      else if (r == 7) host_ack();
      else if (r == 8) begin set_tcs(1'b1); set_tcs(1'b0); end
      else             host_clr();
      check_all(tag);
    end
  endtask

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] seq;
    int unsigned words[5];
    int unsigned base;

    ifa.iTxD_DATA = '0; ifa.iTxD_Start = 1'b0; ifa.iRxD_Ack = 1'b0; ifa.iClr_Status = 1'b0;
    ifb.iTxD_DATA = '0; ifb.iTxD_Start = 1'b0; ifb.iRxD_Ack = 1'b0; ifb.iClr_Status = 1'b0;

    // -------- instance A: 8-bit words, 4-deep FIFOs --------
    use_dut(0);
    check_all("reset");
    set_tcs(1'b0);

    send_word('hA5);
    check_eq("rx_a5.data", 32'(o_data), 'hA5);
    check_eq("rx_a5.level", 32'(o_level), 1);
    check_all("rx_a5");
    host_ack();
    check_eq("rx_a5.ack_ready", 32'(o_ready), 0);
    check_all("rx_a5_ack");

    host_push('h3C);
    host_push('h81);
    seq = 16'h813C;
    base = m_done;
    for (int i = 0; i < 16; i++) begin
      tck_pulse(1'b0, 4, 4);
      check_eq("tx_pair.tdo_seq", 32'(o_tdo), 32'(seq[i]));
      check_all("tx_pair");
    end
    check_eq("tx_pair.done_count", done_seen, base + 2);
    for (int i = 0; i < 8; i++) begin
      tck_pulse(1'b0, 4, 4);
      check_eq("tx_idle.tdo", 32'(o_tdo), 0);
    end
    check_eq("tx_idle.done_count", done_seen, base + 2);
    drain_rx();
    check_all("drained");

    for (int k = 0; k < 5; k++) begin
      words[k] = $urandom_range(0, 255);
      send_word(words[k]);
    end
    check_eq("ovf.level", 32'(o_level), 4);
    check_eq("ovf.flag", 32'(o_ovf), 1);
    check_all("ovf");
    for (int k = 0; k < 4; k++) begin
      check_eq("ovf.word", 32'(o_data), words[k]);
      host_ack();
    end
    host_clr();
    check_eq("ovf.clear", 32'(o_ovf), 0);
    check_all("ovf_clr");

    host_push('h96);
    for (int i = 0; i < 3; i++) tck_pulse(1'b1, 4, 4);
    base = m_done;
    set_tcs(1'b1);
    check_eq("abort.flag", 32'(o_abort), 1);
    check_eq("abort.level", 32'(o_level), 0);
    check_eq("abort.tdo", 32'(o_tdo), 0);
    check_all("abort");
    set_tcs(1'b0);
    host_push('h5A);
    send_word('hC3);
    check_eq("abort.next_rx", 32'(o_data), 'hC3);
    check_eq("abort.next_done", done_seen, base + 1);
    check_all("after_abort");
    host_clr();
    drain_rx();

    for (int k = 0; k < 5; k++) host_push(k + 1);
    check_eq("tx_full.flag", 32'(o_full), 1);
    check_all("tx_full");
    send_word('h11);
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 4, 4);
    check_all("pre_reset");
    do_reset();
    check_eq("mid_reset.level", 32'(o_level), 0);
    check_eq("mid_reset.full", 32'(o_full), 0);
    check_all("post_reset");
    set_tcs(1'b0);

    random_ops(300, "rand_a");

    // -------- instance B: 12-bit words, loopback --------
    use_dut(1);
    set_tcs(1'b0);
    send_word('hABC);
    check_eq("w12.data", 32'(o_data), 'hABC);
    check_all("w12");
    host_ack();
    loop_en = 1'b1;
    for (int k = 0; k < 4; k++) host_push($urandom);
    random_ops(300, "rand_loop");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
